// File: rtl/sonic_v1_15_pcs_eth_10g_mac_rx_st_overflow_fifo.sv
// Packet-aware RX overflow FIFO behind the 10G MAC RX timing adapter.
// The upstream cannot be stalled, so packets are truncated or dropped when space runs out.
module sonic_v1_15_pcs_eth_10g_mac_rx_st_overflow_fifo #(
    parameter int DATA_W  = 72,
    parameter int DEPTH   = 16,
    parameter int SOP_BIT = 64,
    parameter int EOP_BIT = 65,
    parameter int ERR_BIT = 69,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO     = (AW+1)'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [AW:0]         free;
    logic                wr_en;
    logic                pop;
    logic                drop_inc;
    logic                in_sop;
    logic                in_eop;
    logic [DATA_W-1:0]   wr_data;

    assign in_sop     = in_data[SOP_BIT];
    assign in_eop     = in_data[EOP_BIT];
    // Room is judged on the start-of-cycle count; a same-cycle pop never helps the write.
    assign free       = DEPTH_C - count;
    assign out_valid  = (count != '0);
    assign out_data   = mem[rd_ptr];
    assign pop        = out_valid && out_ready;
    assign fill_level = count;

    // A packet only starts with two free slots, so a truncating EOP always fits.
    always_comb begin
        wr_en     = 1'b0;
        wr_data   = in_data;
        drop_inc  = 1'b0;
        state_nxt = state;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (in_sop) begin
                        if (free >= TWO) begin
                            wr_en     = 1'b1;
                            state_nxt = in_eop ? IDLE : PASS;
                        end else begin
                            drop_inc  = 1'b1;
                            state_nxt = in_eop ? IDLE : DROP;
                        end
                    end
                end
                PASS: begin
                    if (in_eop) begin
                        wr_en     = (free != '0);
                        state_nxt = IDLE;
                    end else if (free >= TWO) begin
                        wr_en     = 1'b1;
                    end else if (free != '0) begin
                        wr_en            = 1'b1;
                        wr_data[EOP_BIT] = 1'b1;
                        wr_data[ERR_BIT] = 1'b1;
                        drop_inc         = 1'b1;
                        state_nxt        = DROP;
                    end
                end
                DROP: begin
                    if (in_eop) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            in_ready   <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop_inc && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    a_no_valid_after_reset: assert property (@(posedge clk) !reset_n |=> !in_valid);
    a_count_bound:          assert property (@(posedge clk) count <= DEPTH_C);

endmodule

// File: tb/tb_sonic_v1_15_pcs_eth_10g_mac_rx_st_overflow_fifo.sv
// Bench for the RX overflow FIFO: directed scenarios plus randomized traffic
// checked against a queue-based packet model.
module tb_sonic_v1_15_pcs_eth_10g_mac_rx_st_overflow_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [71:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fill_level;
    logic [31:0] drop_count;

    int errors = 0;
    int checks = 0;

    // Model: stored beats, packet state (0 idle, 1 passing, 2 dropping), drop total.
    logic [71:0] q[$];
    int          mst = 0;
    int          mdrop = 0;

    sonic_v1_15_pcs_eth_10g_mac_rx_st_overflow_fifo #(
        .DATA_W(72), .DEPTH(DEPTH), .SOP_BIT(64), .EOP_BIT(65), .ERR_BIT(69), .CNT_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fill_level(fill_level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] mk(input bit sop, input bit eop, input logic [63:0] d,
                                       input logic [5:0] hi);
        logic [71:0] b;
        b        = '0;
        b[63:0]  = d;
        b[64]    = sop;
        b[65]    = eop;
        b[71:66] = hi;
        return b;
    endfunction

    task automatic drive(input bit v, input logic [71:0] d, input bit rdy);
        int          cnt;
        bit          wr;
        logic [71:0] wd;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        cnt = q.size();
        wr  = 1'b0;
        wd  = d;
        if (v) begin
            if (mst == 0) begin
                if (d[64]) begin
                    if (DEPTH - cnt >= 2) begin
                        wr  = 1'b1;
                        mst = d[65] ? 0 : 1;
                    end else begin
                        mdrop++;
                        mst = d[65] ? 0 : 2;
                    end
                end
            end else if (mst == 1) begin
                if (d[65]) begin
                    wr  = 1'b1;
                    mst = 0;
                end else if (DEPTH - cnt >= 2) begin
                    wr = 1'b1;
                end else begin
                    wr     = 1'b1;
                    wd[65] = 1'b1;
                    wd[69] = 1'b1;
                    mdrop++;
                    mst    = 2;
                end
            end else if (d[65]) begin
                mst = 0;
            end
        end
        if (cnt != 0 && rdy) void'(q.pop_front());
        if (wr) q.push_back(wd);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        q.delete();
        mst     = 0;
        mdrop   = 0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready cycle %0d: got %b expected 0", i, in_ready);
            end
        end
        q.delete();
        mst     = 0;
        mdrop   = 0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 4'd0 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b fill=%0d drops=%0d expected 0/0/0",
                     out_valid, fill_level, drop_count);
        end
    endtask

    task automatic test_passthrough;
        logic [71:0] b [4];
        do_reset(1);
        for (int i = 0; i < 4; i++) b[i] = mk(i == 0, i == 3, 64'(i + 1), 6'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, b[i], 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== b[i]) begin
                errors++;
                $display("FAIL pass_beat%0d: got v=%b %h expected %h", i, out_valid, out_data, b[i]);
            end
            checks++;
            if (fill_level > 4'd1) begin
                errors++;
                $display("FAIL pass_fill%0d: got %0d expected <=1", i, fill_level);
            end
        end
        drive(1'b0, '0, 1'b1);
        checks++;
        if (fill_level !== 4'd0 || out_valid !== 1'b0 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL pass_end: fill=%0d valid=%b drops=%0d expected 0/0/0",
                     fill_level, out_valid, drop_count);
        end
    endtask

    task automatic test_truncate;
        logic [71:0] b [10];
        logic [71:0] e;
        do_reset(1);
        for (int i = 0; i < 10; i++) b[i] = mk(i == 0, i == 9, 64'h1000 + 64'(i), 6'h0);
        for (int i = 0; i < 10; i++) drive(1'b1, b[i], 1'b0);
        checks++;
        if (fill_level !== 4'd8 || drop_count !== 32'd1) begin
            errors++;
            $display("FAIL trunc_fill: fill=%0d drops=%0d expected 8/1", fill_level, drop_count);
        end
        for (int i = 0; i < 8; i++) begin
            e = b[i];
            if (i == 7) begin
                e[65] = 1'b1;
                e[69] = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                errors++;
                $display("FAIL trunc_drain%0d: got v=%b %h expected %h", i, out_valid, out_data, e);
            end
            drive(1'b0, '0, 1'b1);
        end
        checks++;
        if (fill_level !== 4'd0) begin
            errors++;
            $display("FAIL trunc_empty: got %0d expected 0", fill_level);
        end
        e = mk(1'b1, 1'b1, 64'hBEEF, 6'h0);
        drive(1'b1, e, 1'b0);
        checks++;
        if (fill_level !== 4'd1 || out_data !== e) begin
            errors++;
            $display("FAIL trunc_idle_after: fill=%0d data=%h expected 1/%h", fill_level, out_data, e);
        end
        drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_full_drop;
        logic [71:0] first;
        do_reset(1);
        first = mk(1'b1, 1'b0, 64'h2000, 6'h0);
        for (int i = 0; i < 8; i++) drive(1'b1, (i == 0) ? first : mk(1'b0, i == 7, 64'h2000 + 64'(i), 6'h0), 1'b0);
        checks++;
        if (fill_level !== 4'd8 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL full_fill: fill=%0d drops=%0d expected 8/0", fill_level, drop_count);
        end
        drive(1'b1, mk(1'b1, 1'b0, 64'h3000, 6'h0), 1'b0);
        drive(1'b1, mk(1'b0, 1'b1, 64'h3001, 6'h0), 1'b0);
        checks++;
        if (fill_level !== 4'd8 || drop_count !== 32'd1 || out_data !== first) begin
            errors++;
            $display("FAIL full_drop: fill=%0d drops=%0d head=%h expected 8/1/%h",
                     fill_level, drop_count, out_data, first);
        end
        drive(1'b0, '0, 1'b1);
        drive(1'b1, mk(1'b1, 1'b1, 64'h4000, 6'h0), 1'b1);
        checks++;
        if (fill_level !== 4'd6 || drop_count !== 32'd2) begin
            errors++;
            $display("FAIL conservative_free: fill=%0d drops=%0d expected 6/2", fill_level, drop_count);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_data !== q[0]) begin
                errors++;
                $display("FAIL full_drain%0d: got %h expected %h", i, out_data, q[0]);
            end
            drive(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_orphan;
        logic [71:0] p0;
        do_reset(1);
        drive(1'b1, mk(1'b0, 1'b1, 64'hAA, 6'h0), 1'b0);
        drive(1'b1, mk(1'b0, 1'b0, 64'hBB, 6'h0), 1'b0);
        checks++;
        if (fill_level !== 4'd0 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL orphan: fill=%0d drops=%0d expected 0/0", fill_level, drop_count);
        end
        p0 = mk(1'b1, 1'b0, 64'h5000, 6'h0);
        drive(1'b1, p0, 1'b0);
        drive(1'b1, mk(1'b0, 1'b1, 64'h5001, 6'h0), 1'b0);
        checks++;
        if (fill_level !== 4'd2 || out_data !== p0) begin
            errors++;
            $display("FAIL orphan_next: fill=%0d head=%h expected 2/%h", fill_level, out_data, p0);
        end
    endtask

    task automatic test_midreset;
        logic [71:0] b [3];
        do_reset(1);
        for (int i = 0; i < 3; i++) drive(1'b1, mk(i == 0, 1'b0, 64'h6000 + 64'(i), 6'h0), 1'b0);
        checks++;
        if (fill_level !== 4'd3) begin
            errors++;
            $display("FAIL midreset_pre: got %0d expected 3", fill_level);
        end
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (fill_level !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset: fill=%0d valid=%b ready=%b expected 0/0/0",
                     fill_level, out_valid, in_ready);
        end
        q.delete();
        mst     = 0;
        mdrop   = 0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, mk(1'b0, 1'b0, 64'h6003, 6'h0), 1'b0);
        drive(1'b1, mk(1'b0, 1'b1, 64'h6004, 6'h0), 1'b0);
        checks++;
        if (fill_level !== 4'd0 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL midreset_orphans: fill=%0d drops=%0d expected 0/0", fill_level, drop_count);
        end
        for (int i = 0; i < 3; i++) b[i] = mk(i == 0, i == 2, 64'h7000 + 64'(i), 6'h15);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, b[i], 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== b[i]) begin
                errors++;
                $display("FAIL midreset_fresh%0d: got %h expected %h", i, out_data, b[i]);
            end
        end
        drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_random;
        int          rem = 0;
        int          phase = 0;
        bit          first = 1'b0;
        bit          v;
        bit          rdy;
        logic [71:0] b;
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) phase = $urandom_range(0, 2);
            rdy = (phase == 0) ? ($urandom % 8 == 0) : (phase == 1) ? 1'($urandom % 2) : 1'b1;
            v = 1'b0;
            b = '0;
            if (rem == 0 && $urandom % 4 == 0) begin
                rem   = $urandom_range(1, 12);
                first = 1'b1;
            end
            if (rem > 0 && $urandom % 5 != 0) begin
                v     = 1'b1;
                b     = mk(first, rem == 1, {$urandom, $urandom}, 6'($urandom));
                first = 1'b0;
                rem--;
            end else if (rem == 0 && $urandom % 30 == 0) begin
                v = 1'b1;
                b = mk(1'b0, 1'($urandom % 2), {$urandom, $urandom}, 6'($urandom));
            end
            drive(v, b, rdy);
            checks++;
            if (int'(fill_level) != q.size() || out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_fill c=%0d: fill=%0d valid=%b expected %0d", c, fill_level, out_valid, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data c=%0d: got %h expected %h", c, out_data, q[0]);
                end
            end
            checks++;
            if (drop_count !== 32'(mdrop)) begin
                errors++;
                $display("FAIL rand_drops c=%0d: got %0d expected %0d", c, drop_count, mdrop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_truncate();
        test_full_drop();
        test_orphan();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
